// File: rtl/sm83_alu_serial_if.sv
// Handshake and data bundle for the slice-serial SM83 ALU sequencer.
interface sm83_alu_serial_if #(
    parameter int WORD_WIDTH  = 16,
    parameter int SLICE_WIDTH = 4
);
    localparam int NSLICES = WORD_WIDTH / SLICE_WIDTH;
    localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;

    logic                  start;
    logic [2:0]            op;
    logic                  carry_in;
    logic [WORD_WIDTH-1:0] a;
    logic [WORD_WIDTH-1:0] b;
    logic                  busy;
    logic                  done;
    logic [WORD_WIDTH-1:0] result;
    logic                  flag_c;
    logic                  flag_h;
    logic                  flag_z;
    logic                  flag_n;
    logic [IDXW-1:0]       slice_idx;

    modport master (
        output start, op, carry_in, a, b,
        input  busy, done, result, flag_c, flag_h, flag_z, flag_n, slice_idx
    );

    modport slave (
        input  start, op, carry_in, a, b,
        output busy, done, result, flag_c, flag_h, flag_z, flag_n, slice_idx
    );
endinterface

// File: rtl/sm83_alu_serial.sv
// Slice-serial ALU sequencer: iterates a SLICE_WIDTH ripple-carry core over a
// WORD_WIDTH word, LSB slice first, with a registered inter-slice carry.
//
// state | meaning
// IDLE  | waiting for start, last result/flags held
// RUN   | one slice processed per edge, slice_idx selects it
// DONE  | done pulse cycle; start here is accepted back-to-back
module sm83_alu_serial #(
    parameter int WORD_WIDTH  = 16,
    parameter int SLICE_WIDTH = 4
) (
    input logic               clk,
    input logic               reset,
    sm83_alu_serial_if.slave  bus
);
    localparam int NSLICES = WORD_WIDTH / SLICE_WIDTH;
    localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [WORD_WIDTH-1:0] a_q;
    logic [WORD_WIDTH-1:0] b_q;
    logic [WORD_WIDTH-1:0] acc;
    logic [2:0]            op_q;
    logic                  carry_q;
    logic                  h_q;
    logic [IDXW-1:0]       idx;

    logic                   init_carry;
    logic [SLICE_WIDTH-1:0] a_sl;
    logic [SLICE_WIDTH-1:0] b_sl;
    logic [SLICE_WIDTH-1:0] slice_res;
    logic [SLICE_WIDTH:0]   sum;
    logic [WORD_WIDTH-1:0]  acc_next;
    logic                   is_sub;
    logic                   h_raw;
    logic                   last;
    logic                   fc_next;
    logic                   fh_next;

    assign bus.slice_idx = idx;

    // Carry seeded into slice 0 when an operation is accepted.
    always_comb begin
        case (bus.op)
            OP_ADC:        init_carry = bus.carry_in;
            OP_SUB, OP_CP: init_carry = 1'b1;
            OP_SBC:        init_carry = ~bus.carry_in;
            default:       init_carry = 1'b0;
        endcase
    end

    // Current slice datapath and the flags that would be latched on the final slice.
    always_comb begin
        is_sub = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
        a_sl   = a_q[idx*SLICE_WIDTH +: SLICE_WIDTH];
        b_sl   = b_q[idx*SLICE_WIDTH +: SLICE_WIDTH];
        if (is_sub)
            b_sl = ~b_sl;
        sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_WIDTH{1'b0}}, carry_q};
        case (op_q)
            OP_AND:  slice_res = a_sl & b_sl;
            OP_XOR:  slice_res = a_sl ^ b_sl;
            OP_OR:   slice_res = a_sl | b_sl;
            default: slice_res = sum[SLICE_WIDTH-1:0];
        endcase
        acc_next = acc;
        acc_next[idx*SLICE_WIDTH +: SLICE_WIDTH] = slice_res;
        // With a single slice the half-carry is produced on the same edge as the carry.
        h_raw = (idx == '0) ? sum[SLICE_WIDTH] : h_q;
        last  = (idx == IDXW'(NSLICES - 1));
        case (op_q)
            OP_ADD, OP_ADC:         begin fc_next = sum[SLICE_WIDTH];  fh_next = h_raw;  end
            OP_SUB, OP_SBC, OP_CP:  begin fc_next = ~sum[SLICE_WIDTH]; fh_next = ~h_raw; end
            OP_AND:                 begin fc_next = 1'b0;              fh_next = 1'b1;   end
            default:                begin fc_next = 1'b0;              fh_next = 1'b0;   end
        endcase
    end

    // Sequencer: accept, walk the slices, then publish result and flags in one step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc        <= '0;
            op_q       <= OP_ADD;
            carry_q    <= 1'b0;
            h_q        <= 1'b0;
            idx        <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.flag_c <= 1'b0;
            bus.flag_h <= 1'b0;
            bus.flag_z <= 1'b0;
            bus.flag_n <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    carry_q <= sum[SLICE_WIDTH];
                    acc     <= acc_next;
                    if (idx == '0)
                        h_q <= sum[SLICE_WIDTH];
                    if (last) begin
                        state      <= DONE;
                        idx        <= '0;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        bus.result <= (op_q == OP_CP) ? a_q : acc_next;
                        bus.flag_c <= fc_next;
                        bus.flag_h <= fh_next;
                        bus.flag_z <= (acc_next == '0);
                        bus.flag_n <= is_sub;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        state    <= RUN;
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        op_q     <= bus.op;
                        carry_q  <= init_carry;
                        acc      <= '0;
                        idx      <= '0;
                        bus.busy <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sm83_alu_serial.sv
// Scoreboard bench for sm83_alu_serial at 16/4 and 8/4.
module tb_sm83_alu_serial;
    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        h;
        logic        z;
        logic        n;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sm83_alu_serial_if #(.WORD_WIDTH(16), .SLICE_WIDTH(4)) bus16();
    sm83_alu_serial_if #(.WORD_WIDTH(8),  .SLICE_WIDTH(4)) bus8();

    sm83_alu_serial #(.WORD_WIDTH(16), .SLICE_WIDTH(4)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
    sm83_alu_serial #(.WORD_WIDTH(8),  .SLICE_WIDTH(4)) dut8  (.clk(clk), .reset(reset), .bus(bus8));

    int tests  = 0;
    int failed = 0;
    exp_t q16[$];
    exp_t q8[$];
    logic [15:0] last_res16 = '0;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic; H is taken at the 4-bit nibble boundary.
    function automatic exp_t model(input int w, input logic [2:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic cin);
        exp_t e;
        longint mask, ua, ub, la, lb, k, r;
        mask = (64'd1 << w) - 1;
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        la = ua & 15;
        lb = ub & 15;
        e = '0;
        r = 0;
        case (op)
            3'd0, 3'd1: begin
                k = (op == 3'd1) ? longint'(cin) : 0;
                r = ua + ub + k;
                e.c = (r > mask);
                e.h = ((la + lb + k) > 15);
            end
            3'd2, 3'd3, 3'd7: begin
                k = (op == 3'd3) ? longint'(cin) : 0;
                r = ua - ub - k;
                e.c = (ua < ub + k);
                e.h = (la < lb + k);
                e.n = 1'b1;
            end
            3'd4: begin r = ua & ub; e.h = 1'b1; end
            3'd5: r = ua ^ ub;
            default: r = ua | ub;
        endcase
        r = r & mask;
        e.z = (r == 0);
        e.res = (op == 3'd7) ? 16'(ua) : 16'(r);
        return e;
    endfunction

    // Monitor, 16-bit instance: compare on done, check result holds while busy.
    always @(negedge clk) begin
        exp_t e;
        if (bus16.done) begin
            if (q16.size() == 0) begin
                check1("unexpected_done16", 32'd1, 32'd0);
            end else begin
                e = q16.pop_front();
                check1("result16", bus16.result, e.res);
                check1("flag_c16", bus16.flag_c, e.c);
                check1("flag_h16", bus16.flag_h, e.h);
                check1("flag_z16", bus16.flag_z, e.z);
                check1("flag_n16", bus16.flag_n, e.n);
                last_res16 = e.res;
            end
        end else if (bus16.busy && !reset) begin
            check1("hold_result16", bus16.result, last_res16);
        end
    end

    // Monitor, 8-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (bus8.done) begin
            if (q8.size() == 0) begin
                check1("unexpected_done8", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                check1("result8", bus8.result, e.res[7:0]);
                check1("flag_c8", bus8.flag_c, e.c);
                check1("flag_h8", bus8.flag_h, e.h);
                check1("flag_z8", bus8.flag_z, e.z);
                check1("flag_n8", bus8.flag_n, e.n);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input bit expect_b2b);
        int n = 0;
        @(negedge clk);
        while (bus16.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check1("issue_timeout", 32'd1, 32'd0);
        if (expect_b2b) check1("b2b_in_done_cycle", bus16.done, 32'd1);
        bus16.op = op; bus16.a = a; bus16.b = b; bus16.carry_in = cin;
        bus16.start = 1'b1;
        @(posedge clk);
        q16.push_back(model(16, op, a, b, cin));
        #1;
        check1("accept_busy16", bus16.busy, 32'd1);
        bus16.start = 1'b0;
    endtask

    // Counts edges from the accept edge (inclusive) to the one raising done.
    task automatic timed16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic cin);
        int busy_cnt = 0;
        int lat = 1;
        issue(op, a, b, cin, 1'b0);
        while (!bus16.done && lat < 50) begin
            @(negedge clk);
            if (bus16.busy) begin
                check1("slice_idx", 32'(bus16.slice_idx), 32'(busy_cnt));
                busy_cnt++;
            end
            if (!bus16.done) lat++;
        end
        check1("busy_cycles16", busy_cnt, 32'd4);
        check1("latency16", lat, 32'd5);
        @(negedge clk);
        check1("done_pulse_width16", bus16.done, 32'd0);
    endtask

    task automatic timed8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic cin);
        int lat = 1;
        @(negedge clk);
        bus8.op = op; bus8.a = a; bus8.b = b; bus8.carry_in = cin;
        bus8.start = 1'b1;
        @(posedge clk);
        q8.push_back(model(8, op, {8'h00, a}, {8'h00, b}, cin));
        #1 bus8.start = 1'b0;
        @(negedge clk);
        while (!bus8.done && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        check1("latency8", lat, 32'd3);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus16.start = 1'b0; bus16.op = '0; bus16.a = '0; bus16.b = '0; bus16.carry_in = 1'b0;
        bus8.start  = 1'b0; bus8.op  = '0; bus8.a  = '0; bus8.b  = '0; bus8.carry_in  = 1'b0;
        repeat (2) @(negedge clk);
        check1("rst_busy", bus16.busy, 32'd0);
        check1("rst_done", bus16.done, 32'd0);
        check1("rst_result", bus16.result, 32'd0);
        check1("rst_flags", {bus16.flag_c, bus16.flag_h, bus16.flag_z, bus16.flag_n}, 32'd0);
        check1("rst_slice_idx", 32'(bus16.slice_idx), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        timed16(3'd0, 16'h0FFF, 16'h0001, 1'b0);
        issue(3'd2, 16'h1000, 16'h0001, 1'b0, 1'b0);
        issue(3'd2, 16'h0000, 16'h0001, 1'b0, 1'b1);
        issue(3'd3, 16'h0005, 16'h0002, 1'b1, 1'b1);
        issue(3'd1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
        issue(3'd0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        issue(3'd4, 16'h00F0, 16'h0F0F, 1'b0, 1'b1);
        issue(3'd6, 16'h00F0, 16'h0F0F, 1'b0, 1'b1);
        issue(3'd7, 16'h1234, 16'h1234, 1'b0, 1'b1);

        // start poked mid-RUN with other operands must be ignored.
        issue(3'd0, 16'h1111, 16'h2222, 1'b0, 1'b1);
        @(negedge clk);
        bus16.op = 3'd5; bus16.a = 16'hAAAA; bus16.b = 16'h5555; bus16.start = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;

        // Reset in the second RUN cycle discards the operation.
        issue(3'd7, 16'h8000, 16'h0001, 1'b0, 1'b1);
        @(negedge clk);
        while (bus16.busy) @(negedge clk);
        @(negedge clk);
        bus16.op = 3'd0; bus16.a = 16'h4321; bus16.b = 16'h1111; bus16.start = 1'b1;
        @(posedge clk);
        #1 bus16.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        last_res16 = '0;
        #1;
        check1("midrun_rst_busy", bus16.busy, 32'd0);
        check1("midrun_rst_done", bus16.done, 32'd0);
        check1("midrun_rst_result", bus16.result, 32'd0);
        check1("midrun_rst_flags", {bus16.flag_c, bus16.flag_h, bus16.flag_z, bus16.flag_n}, 32'd0);
        check1("midrun_rst_slice_idx", 32'(bus16.slice_idx), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check1("post_rst_idle", bus16.busy, 32'd0);

        // Randomised back-to-back traffic.
        issue(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i < 60; i++) begin
            logic [15:0] ra;
            ra = 16'($urandom);
            issue(3'($urandom_range(0, 7)), ra,
                  ($urandom_range(0, 5) == 0) ? ra : 16'($urandom), 1'($urandom), 1'b1);
        end

        // 8-bit instance.
        timed8(3'd0, 8'hFF, 8'h01, 1'b0);
        timed8(3'd2, 8'h10, 8'h01, 1'b0);
        for (int i = 0; i < 10; i++)
            timed8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom));

        for (int n = 0; n < 100 && (q16.size() != 0 || q8.size() != 0); n++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        check1("drain_q16", q16.size(), 32'd0);
        check1("drain_q8", q8.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/sm83_alu_serial.md
# sm83_alu_serial

Parametrised, slice-serial ALU sequencer. It performs 8 Z80/SM83-style arithmetic/logic operations on WORD_WIDTH-bit operands by iterating a SLICE_WIDTH-bit ripple-carry core over the word, LSB slice first, with a registered inter-slice carry. It sits beside the nibble ALU in the CPU datapath and handles 16-bit (or wider) operations that the 8-bit path cannot cover. It uses a start/busy/done handshake and reports C/H/Z/N flags.

## Interface
- WORD_WIDTH, 16, operand/result width; must be an integer multiple of SLICE_WIDTH and ≥ SLICE_WIDTH.
- SLICE_WIDTH, 4, bits processed per cycle; NSLICES = WORD_WIDTH/SLICE_WIDTH.
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted when state ≠ RUN.
- op  in  3  operation code: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP.
- carry_in  in  1  incoming C flag; used by ADC/SBC only.
- a, b  in  WORD_WIDTH  operands; sampled only on the accept edge.
- busy  out  1  high while slices are being processed (state RUN).
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- result  out  WORD_WIDTH  operation result.
- flag_c, flag_h, flag_z, flag_n  out  1  carry/borrow, half-carry/borrow, zero, subtract.
- slice_idx  out  $clog2(NSLICES) (min 1)  index of the slice processed on the next edge (debug).

## Operation
- States: IDLE, RUN, DONE.
  - IDLE/DONE + start → RUN. Capture a, b, op and the initial carry. Set slice_idx=0.
  - RUN: on each edge, compute slice slice_idx into the internal accumulator, register the slice carry-out, and increment slice_idx. On the edge that processes slice NSLICES-1 → DONE.
  - DONE: done=1 for exactly this cycle. Without start → IDLE; with start → RUN (back-to-back accepted).
- start during RUN is ignored. There is no queueing and the captured operands are unaffected.
- Arithmetic per slice is SLICE_WIDTH-bit ripple add of a_slice + b'_slice + c, where b' = ~b for SUB/SBC/CP, else b.
- Initial carry:
  - ADD: 0
  - ADC: carry_in
  - SUB/CP: 1
  - SBC: !carry_in
- Carry and half-carry:
  - Final carry C_raw = carry out of the top slice; H_raw = carry out of slice 0 (bit SLICE_WIDTH-1).
  - ADD/ADC: flag_c=C_raw, flag_h=H_raw.
  - SUB/SBC/CP: flag_c=!C_raw, flag_h=!H_raw (borrow convention).
- Logic ops are computed bitwise per slice. Carry is ignored. flag_c=0. flag_h=1 for AND, 0 for XOR/OR.
- result:
  - All ops except CP: the computed word.
  - CP: result=a (unchanged). Flags are computed from the difference a-b.
- flag_z: 1 iff the computed word (the difference, for CP) is all zeros.
- flag_n: 1 for SUB/SBC/CP, else 0.
- result and all flags update only on the RUN→DONE edge. They hold until the next RUN→DONE edge and never show partial values.
- Reset (any time, including mid-RUN): state=IDLE, busy=0, done=0, result=0, all flags 0, slice_idx=0. An in-flight operation is discarded and produces no done.

## Timing
- Accept edge E0 (start=1, state≠RUN).
- busy is high in the NSLICES cycles following E0 (edges E1..E_NSLICES process slices 0..NSLICES-1).
- done is high in the cycle after E_NSLICES. Latency start→done is NSLICES+1 edges: 5 cycles for 16/4, 3 for 8/4.
- Throughput with start held high: one result every NSLICES+1 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Reset is asynchronous assert; deassertion is synchronised externally.

## Test plan
- ADD a=0x0FFF, b=0x0001 (16/4) → result=0x1000, C=0, H=1, Z=0, N=0; busy for 4 cycles; done pulse exactly 1 cycle, 5 edges after accept.
- SUB 0x1000−0x0001 → 0x0FFF, N=1, H=1, C=0. SUB 0x0000−0x0001 → 0xFFFF, C=1, H=1. SBC 0x0005−0x0002 with carry_in=1 → 0x0002, C=0.
- ADC a=0xFFFF, b=0x0000, carry_in=1 → 0x0000, Z=1, C=1, H=1. ADD 0x0000+0x0000 → Z=1, C=0, H=0.
- CP a=b=0x1234 → result=0x1234, Z=1, N=1, C=0, H=0. AND 0x00F0&0x0F0F → 0x0000, Z=1, H=1, C=0. OR 0x00F0|0x0F0F → 0x0FFF, H=0.
- Handshake:
  - start pulsed mid-RUN with different a/b/op → ignored; the original result is delivered.
  - start held during the DONE cycle → next op accepted with no idle gap.
  - Previous result holds while busy.
- Reset asserted in the 2nd RUN cycle → busy/done/result/flags immediately 0, no done pulse. Re-parametrise to WORD_WIDTH=8: ADD 0xFF+0x01 → 0x00, Z=1, C=1, H=1; done 3 edges after accept.
